snake_input_ctrl: RTL
=====================

Name: snake_input_ctrl

Overview:
Input-side counterpart to the game top's display outputs. Conditions the five raw push-buttons (sync, debounce, press detect) in the board_clk domain. Turns direction presses into a validated direction command, held until the game core acknowledges it. Also emits a one-cycle Ack/start pulse for BtnC. Sits between the board buttons and snake_core; replaces direct wiring of raw buttons into the slow game clock.

Parameters:
DEBOUNCE_CYCLES, 1000000, board_clk cycles a synced input must hold a new level before it is accepted (10 ms at 100 MHz)
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
RESET_DIR, 2'b11, direction after reset (00 up, 01 down, 10 left, 11 right)

Ports:
board_clk  in  1  system clock
reset  in  1  asynchronous, active-high
btn_u  in  1  raw Up button
btn_d  in  1  raw Down button
btn_l  in  1  raw Left button
btn_r  in  1  raw Right button
btn_c  in  1  raw Centre button
dir_ack  in  1  one-cycle strobe from game side: current command consumed
dir  out  2  direction command: pending value when dir_valid=1, else last committed value
dir_valid  out  1  an unconsumed direction command is pending
ack_pulse  out  1  one-cycle pulse on debounced BtnC press
btn_level  out  5  debounced levels {u,d,l,r,c}

Behaviour:
- Reset, asynchronous, active-high, clock board_clk. All sync flops, stable levels and counters clear to 0. Committed direction = RESET_DIR. dir = RESET_DIR. dir_valid = 0, ack_pulse = 0, btn_level = 0. Reset mid-debounce discards the partial count.
- Per button: 2-FF synchronizer, then debounce.
  - If sync != stable, the counter increments. When the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, stable <= sync and the counter clears.
  - If sync == stable at any cycle, the counter clears. A glitch shorter than DEBOUNCE_CYCLES therefore has no effect.
- Press pulse = stable rising edge, registered, one cycle wide.
  - Latency from raw edge to pulse = 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Release produces no pulse.
- ack_pulse = BtnC press pulse. It is independent of the direction logic.
- Candidate direction on a cycle with any direction press pulse: priority U > D > L > R; lower-priority simultaneous presses are dropped.
- Reference direction = pending value if dir_valid, else committed.
- Candidate is rejected, with no state change, if:
  - it equals the reference direction, or
  - it is the 180° opposite of the reference (U/D, L/R).
- Accepted candidate: pending <= candidate, dir_valid <= 1. A pending value that has not been consumed is overwritten.
- dir_ack while dir_valid: committed <= pending, dir_valid <= 0. dir_ack while !dir_valid is ignored.
- Same-cycle dir_ack and accepted press:
  - Candidate is checked against the old pending value.
  - Commit occurs; the new candidate becomes pending; dir_valid stays 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
SNAKE_INPUT_QUEUE_EN.
- Defined: pending storage becomes a 2-entry FIFO.
  - Reference direction = tail entry if non-empty, else committed.
  - An accepted press pushes; a press while full is dropped.
  - dir = head; dir_valid = non-empty.
  - dir_ack pops the head into committed.
  - Simultaneous push and pop when full: pop, then push is allowed; the count stays 2.
- Undefined: single pending register with overwrite, as above.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=3.
- Reset -> dir=11, dir_valid=0, ack_pulse=0, btn_level=0. Assert reset during a partial count -> counter clears and no pulse follows.
- btn_u held high 3 cycles then low -> no btn_level change and no dir_valid. btn_u held 10 cycles -> dir_valid=1 and dir=00 exactly 7 cycles after the raw edge.
- From committed RIGHT, press L -> rejected, dir_valid stays 0. Press R -> rejected. Press D -> dir=01, dir_valid=1. dir_ack -> dir_valid=0, dir=01 persists.
- U and L press pulses on the same cycle from committed RIGHT -> dir=00 only. Then press D before any ack -> rejected (opposite of pending U). Then press L -> pending overwritten, dir=10.
- Pending U with dir_ack on the same cycle as an L press -> committed=00, dir=10, dir_valid=1. With SNAKE_INPUT_QUEUE_EN: push U, push L, push D -> D dropped; two acks yield 00 then 10.
- btn_c held 10 cycles -> exactly one ack_pulse cycle; no pulse on release.

Source files
------------

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: conditions the five board push-buttons and produces a
// validated, acknowledge-held direction command plus a BtnC start pulse.
// Each raw button passes through a 2-FF synchronizer, a hold-time debouncer
// and a rising-edge detector.
// Build option: define SNAKE_INPUT_QUEUE_EN to hold pending directions in a
// 2-entry FIFO instead of a single overwrite register.
module snake_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter logic [1:0]  RESET_DIR       = 2'b11
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  input  logic       dir_ack,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       ack_pulse,
  output logic [4:0] btn_level
);

  localparam int unsigned NBTN  = 5;
  localparam int unsigned DIR_W = 2;

  // Bit positions inside the {u,d,l,r,c} button vectors
  localparam int unsigned BTN_U = 4;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_C = 0;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  sync1_q;
  logic [NBTN-1:0]  sync2_q;
  logic [NBTN-1:0]  stable_q;
  logic [NBTN-1:0]  stable_d;
  logic [NBTN-1:0]  stable_dly_q;
  logic [NBTN-1:0]  rise_c;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];

  logic             cand_vld_c;
  logic [DIR_W-1:0] cand_c;
  logic [DIR_W-1:0] ref_dir_c;
  logic [DIR_W-1:0] opp_dir_c;
  logic             accept_c;

  logic [DIR_W-1:0] comm_q;
  logic [DIR_W-1:0] comm_d;
  logic [DIR_W-1:0] dir_q;
  logic [DIR_W-1:0] dir_d;
  logic             valid_q;
  logic             valid_d;
  logic             ack_pulse_q;

  assign btn_raw = {btn_u, btn_d, btn_l, btn_r, btn_c};

  // Two-stage synchronizer into the board_clk domain
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a new synced level must persist DEBOUNCE_CYCLES cycles to be accepted
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NBTN); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state; reset discards any partial count
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < int'(NBTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Press = debounced rising edge; consumed on the next clock edge by both outputs
  assign rise_c = stable_q & ~stable_dly_q;

  // Candidate direction from this cycle's presses, priority U > D > L > R
  always_comb begin
    cand_vld_c = |rise_c[BTN_U:BTN_R];
    cand_c     = DIR_RIGHT;
    if (rise_c[BTN_U]) begin
      cand_c = DIR_UP;
    end else if (rise_c[BTN_D]) begin
      cand_c = DIR_DOWN;
    end else if (rise_c[BTN_L]) begin
      cand_c = DIR_LEFT;
    end
  end

  // Reject repeats and 180-degree reversals of the reference direction;
  // opposites differ only in bit 0 with this encoding
  always_comb begin
    opp_dir_c = {ref_dir_c[1], ~ref_dir_c[0]};
    accept_c  = cand_vld_c && (cand_c != ref_dir_c) && (cand_c != opp_dir_c);
  end

`ifdef SNAKE_INPUT_QUEUE_EN

  logic [DIR_W-1:0] fifo_q [2];
  logic [DIR_W-1:0] fifo_d [2];
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             pop_c;

  // Reference is the newest queued entry, falling back to the committed direction
  always_comb begin
    ref_dir_c = comm_q;
    if (count_q == 2'd2) begin
      ref_dir_c = fifo_q[1];
    end else if (count_q == 2'd1) begin
      ref_dir_c = fifo_q[0];
    end
  end

  // Pop into committed first so a full queue can accept a push on the same cycle
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    comm_d  = comm_q;
    pop_c   = dir_ack && (count_q != 2'd0);
    if (pop_c) begin
      comm_d    = fifo_q[0];
      fifo_d[0] = fifo_q[1];
      count_d   = count_q - 2'd1;
    end
    if (accept_c && (count_d != 2'd2)) begin
      fifo_d[count_d[0]] = cand_c;
      count_d            = count_d + 2'd1;
    end
    valid_d = (count_d != 2'd0);
    dir_d   = valid_d ? fifo_d[0] : comm_d;
  end

  // Pending FIFO storage
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      fifo_q[0] <= RESET_DIR;
      fifo_q[1] <= RESET_DIR;
      count_q   <= 2'd0;
    end else begin
      fifo_q  <= fifo_d;
      count_q <= count_d;
    end
  end

`else

  logic [DIR_W-1:0] pend_q;
  logic [DIR_W-1:0] pend_d;
  logic             commit_c;

  // Reference is the pending command if one exists, else the committed direction
  always_comb begin
    ref_dir_c = valid_q ? pend_q : comm_q;
  end

  // Single pending slot: ack commits it, an accepted press overwrites it
  always_comb begin
    pend_d   = pend_q;
    comm_d   = comm_q;
    valid_d  = valid_q;
    commit_c = dir_ack && valid_q;
    if (commit_c) begin
      comm_d  = pend_q;
      valid_d = 1'b0;
    end
    if (accept_c) begin
      pend_d  = cand_c;
      valid_d = 1'b1;
    end
    dir_d = valid_d ? pend_d : comm_d;
  end

  // Pending register storage
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      pend_q <= RESET_DIR;
    end else begin
      pend_q <= pend_d;
    end
  end

`endif

  // Committed direction and registered outputs
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      comm_q      <= RESET_DIR;
      dir_q       <= RESET_DIR;
      valid_q     <= 1'b0;
      ack_pulse_q <= 1'b0;
    end else begin
      comm_q      <= comm_d;
      dir_q       <= dir_d;
      valid_q     <= valid_d;
      ack_pulse_q <= rise_c[BTN_C];
    end
  end

  assign dir       = dir_q;
  assign dir_valid = valid_q;
  assign ack_pulse = ack_pulse_q;
  assign btn_level = stable_q;

endmodule
